// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID pipeline register.
//   Runs from a PC register and issues reads to the icache.
//   Hazard stalls freeze the front end. A taken branch or jump
//   squashes the fetched word. A redirect that arrives while an
//   icache miss is outstanding waits in DRAIN until that access
//   completes. HALT parks the unit until reset.
// Ports:
//   CLK, RST        clock (rising edge), async active-high reset
//   ihit, imemload  icache hit strobe and returned instruction word
//   imemREN         instruction read request
//   imemaddr        instruction fetch address
//   hazard          stall request from the hazard unit
//   branch, jump    taken branch / jump resolved in ID
//   branch_target   branch destination
//   jump_target     jump destination
//   halt            HALT decoded in ID
//   if_instr        IF/ID instruction word
//   if_npc          IF/ID PC+4
//   if_valid        IF/ID holds a real instruction
//   fetch_count     instructions accepted into IF/ID
module fetch_unit #(
   parameter logic [31:0] PC_INIT  = 32'h0,
   parameter logic [31:0] NOP_WORD = 32'h0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        hazard,
   input  logic        branch,
   input  logic        jump,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic        halt,
   output logic [31:0] if_instr,
   output logic [31:0] if_npc,
   output logic        if_valid,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] saved_target;
   logic        redirect;
   logic [31:0] redirect_target;

   assign redirect        = (jump | branch) & ~hazard;
   assign redirect_target = jump ? jump_target : branch_target;

   // The PC is not advanced during DRAIN, so the outstanding miss
   // address is simply the PC.
   assign imemaddr = pc;
   assign imemREN  = (state != HALTED);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= FETCH;
         pc           <= PC_INIT;
         saved_target <= '0;
         if_instr     <= NOP_WORD;
         if_npc       <= '0;
         if_valid     <= 1'b0;
         fetch_count  <= '0;
      end else begin
         case (state)
            FETCH, DRAIN: begin
               if (!hazard) begin
                  if (halt) begin
                     if_instr <= NOP_WORD;
                     if_npc   <= '0;
                     if_valid <= 1'b0;
                     state    <= HALTED;
                  end else if (redirect) begin
                     if_instr <= NOP_WORD;
                     if_npc   <= '0;
                     if_valid <= 1'b0;
                     // A hit this cycle completes the pending access,
                     // so the target can be taken at once.
                     if (ihit) begin
                        pc    <= redirect_target;
                        state <= FETCH;
                     end else begin
                        saved_target <= redirect_target;
                        state        <= DRAIN;
                     end
                  end else if (state == DRAIN) begin
                     if (ihit) begin
                        pc    <= saved_target;
                        state <= FETCH;
                     end
                  end else if (ihit) begin
                     if_instr    <= imemload;
                     if_npc      <= pc + 32'd4;
                     if_valid    <= 1'b1;
                     pc          <= pc + 32'd4;
                     fetch_count <= fetch_count + 32'd1;
                  end
               end
            end
            HALTED: ;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] P_INIT = 32'h0;
   localparam logic [31:0] P_NOP  = 32'h0BAD_F00D;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        ihit = 1'b0;
   logic [31:0] imemload = '0;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        hazard = 1'b0;
   logic        branch = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] jump_target = '0;
   logic        halt = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_npc;
   logic        if_valid;
   logic [31:0] fetch_count;

   int checks = 0;
   int failures = 0;

   // Reference model: architectural view of the fetch stage.
   logic [31:0] m_pc, m_saved, m_instr, m_npc, m_count;
   logic        m_valid, m_halted, m_draining;

   fetch_unit #(.PC_INIT(P_INIT), .NOP_WORD(P_NOP)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN), .imemaddr(imemaddr), .hazard(hazard),
      .branch(branch), .jump(jump), .branch_target(branch_target),
      .jump_target(jump_target), .halt(halt), .if_instr(if_instr),
      .if_npc(if_npc), .if_valid(if_valid), .fetch_count(fetch_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("imemaddr", imemaddr, m_pc);
      chk("imemREN", {31'd0, imemREN}, {31'd0, ~m_halted});
      chk("if_instr", if_instr, m_instr);
      chk("if_npc", if_npc, m_npc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("fetch_count", fetch_count, m_count);
   endtask

   task automatic model_reset();
      m_pc = P_INIT; m_saved = '0; m_instr = P_NOP; m_npc = '0;
      m_valid = 1'b0; m_count = '0; m_halted = 1'b0; m_draining = 1'b0;
   endtask

   task automatic model_bubble();
      m_instr = P_NOP; m_npc = '0; m_valid = 1'b0;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      tgt = jump ? jump_target : branch_target;
      if (m_halted || hazard) return;
      if (halt) begin
         model_bubble();
         m_halted = 1'b1;
         m_draining = 1'b0;
      end else if (jump || branch) begin
         model_bubble();
         if (ihit) begin
            m_pc = tgt;
            m_draining = 1'b0;
         end else begin
            m_saved = tgt;
            m_draining = 1'b1;
         end
      end else if (m_draining) begin
         if (ihit) begin
            m_pc = m_saved;
            m_draining = 1'b0;
         end
      end else if (ihit) begin
         m_instr = imemload;
         m_npc = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc = m_pc + 32'd4;
         m_count = m_count + 32'd1;
      end
   endtask

   // Drive inputs at the falling edge, apply the rising edge, check #1 later.
   task automatic cycle(input logic h, input logic [31:0] ld, input logic hz,
                        input logic br, input logic jp, input logic [31:0] bt,
                        input logic [31:0] jt, input logic hl);
      ihit = h; imemload = ld; hazard = hz; branch = br; jump = jp;
      branch_target = bt; jump_target = jt; halt = hl;
      @(posedge CLK);
      model_step();
      #1 check_all();
      @(negedge CLK);
   endtask

   task automatic async_reset();
      #2 RST = 1'b1;
      model_reset();
      #1 check_all();
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      model_reset();
      // Reset asserted away from any clock edge must act immediately.
      #2 RST = 1'b1;
      #1 check_all();
      @(negedge CLK);
      RST = 1'b0;

      // Three sequential hits.
      cycle(1, 32'hAAAA_0001, 0, 0, 0, 0, 0, 0);
      cycle(1, 32'hBBBB_0002, 0, 0, 0, 0, 0, 0);
      cycle(1, 32'hCCCC_0003, 0, 0, 0, 0, 0, 0);
      chk("seq_count", fetch_count, 32'd3);
      chk("seq_npc", if_npc, 32'd12);

      // Reach PC=0x40 with a valid IF/ID, then stall with hits present.
      cycle(1, 32'h1111_1111, 0, 0, 1, 0, 32'h3C, 0);
      cycle(1, 32'h2222_2222, 0, 0, 0, 0, 0, 0);
      chk("pre_stall_pc", imemaddr, 32'h40);
      cycle(1, 32'h3333_3333, 1, 1, 1, 32'h900, 32'h904, 1);
      cycle(1, 32'h4444_4444, 1, 0, 0, 0, 0, 0);
      chk("stall_instr", if_instr, 32'h2222_2222);
      cycle(1, 32'h5555_5555, 0, 0, 0, 0, 0, 0);
      chk("post_stall_npc", if_npc, 32'h44);

      // Jump with hit: bubble, target becomes fetch address.
      cycle(1, 32'h6666_6666, 0, 0, 1, 0, 32'h40, 0);
      cycle(1, 32'h7777_7777, 0, 1, 1, 32'h80, 32'h100, 0);
      chk("jump_addr", imemaddr, 32'h100);
      chk("jump_valid", {31'd0, if_valid}, 32'd0);

      // Branch on a miss: drain the outstanding access.
      cycle(1, 32'h0, 0, 0, 1, 0, 32'h40, 0);
      cycle(0, 32'h0, 0, 1, 0, 32'h80, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 32'h0, 0, 0, 0, 0, 0, 0);
         chk("drain_addr", imemaddr, 32'h40);
      end
      cycle(1, 32'hDEAD_DEAD, 0, 0, 0, 0, 0, 0);
      chk("drain_done_addr", imemaddr, 32'h80);
      cycle(1, 32'h8888_8888, 0, 0, 0, 0, 0, 0);

      // Last redirect during DRAIN wins.
      cycle(0, 32'h0, 0, 1, 0, 32'h200, 0, 0);
      cycle(0, 32'h0, 0, 0, 1, 0, 32'h300, 0);
      cycle(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      chk("last_redirect", imemaddr, 32'h300);

      // PC+4 wraps at the top of the address space.
      cycle(1, 32'h0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0);
      cycle(1, 32'h9999_9999, 0, 0, 0, 0, 0, 0);
      chk("wrap_npc", if_npc, 32'h0);

      // Halt, then verify nothing moves.
      cycle(1, 32'h0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++)
         cycle(1, $urandom, 0, $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom, $urandom, 0);

      // Reset while draining.
      async_reset();
      cycle(0, 32'h0, 0, 1, 0, 32'h500, 0, 0);
      async_reset();
      cycle(1, 32'hABCD_0000, 0, 0, 0, 0, 0, 0);

      // Randomised traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         if (m_halted && $urandom_range(0, 3) == 0)
            async_reset();
         else
            cycle($urandom_range(0, 9) < 6, $urandom,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 8,
                  $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 59) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0, reset value of the PC.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0, instruction word loaded into the IF/ID register on a bubble.
REQ-003 SHALL have ports: CLK  in  1  clock, all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 ihit  in  1  icache returned valid word for imemaddr this cycle.
REQ-006 imemload  in  32  instruction word, valid when ihit.
REQ-007 imemREN  out  1  instruction read request.
REQ-008 imemaddr  out  32  instruction fetch address.
REQ-009 hazard  in  1  hazard unit stall request, freezes front end.
REQ-010 branch  in  1  hazard unit taken BEQ/BNE resolved in ID.
REQ-011 jump  in  1  hazard unit J/JAL/JR in ID.
REQ-012 branch_target  in  32  branch destination.
REQ-013 jump_target  in  32  J/JAL/JR destination.
REQ-014 halt  in  1  HALT decoded in ID.
REQ-015 if_instr  out  32  IF/ID instruction.
REQ-016 if_npc  out  32  IF/ID PC+4.
REQ-017 if_valid  out  1  IF/ID holds a real instruction, not a bubble.
REQ-018 fetch_count  out  32  number of instructions accepted into IF/ID.

Function
REQ-019 SHALL implement states FETCH, DRAIN, HALTED.
REQ-020 imemaddr SHALL equal PC in FETCH and HALTED, and the held miss address in DRAIN.
REQ-021 imemREN SHALL be 1 in FETCH and DRAIN, 0 in HALTED.
REQ-022 Redirect SHALL mean (jump | branch) with !hazard; target = jump_target if jump, else branch_target (jump wins if both).
REQ-023 Priority per cycle in FETCH SHALL be: hazard > halt > redirect > normal fetch.
REQ-024 hazard=1: PC, IF/ID, fetch_count, state SHALL hold, regardless of ihit, branch, jump, halt.
REQ-025 Normal fetch (FETCH, ihit, no hazard/halt/redirect): IF/ID <= {imemload, PC+4, valid=1}, PC <= PC+4, fetch_count += 1; one-cycle latency on hit.
REQ-026 No ihit and no event: PC and IF/ID SHALL hold; if_valid is unchanged.
REQ-027 Redirect with ihit: PC <= target, IF/ID <= {NOP_WORD, 0, 0}, fetched word discarded, stay FETCH.
REQ-028 Redirect without ihit: IF/ID <= bubble, target SHALL be saved, imemaddr held at PC, go to DRAIN.
REQ-029 DRAIN: on ihit, discard the word, PC <= saved target, go to FETCH; without ihit remain; IF/ID stays bubble.
REQ-030 Redirect arriving in DRAIN SHALL overwrite the saved target (last redirect wins).
REQ-031 halt (no hazard): IF/ID <= bubble, PC frozen, go to HALTED; a pending DRAIN is abandoned.
REQ-032 HALTED SHALL be left only by RST; all outputs are static.
REQ-033 PC+4 SHALL be 32-bit modulo; 32'hFFFFFFFC wraps to 0.
REQ-034 fetch_count SHALL wrap modulo 2^32 and never count discarded words.

Reset
REQ-035 RST=1 SHALL immediately set PC=PC_INIT, state=FETCH, if_instr=NOP_WORD, if_npc=0, if_valid=0, fetch_count=0, saved target=0, independent of CLK.
REQ-036 RST asserted mid-DRAIN or in HALTED SHALL abandon the operation; first fetch after release is at PC_INIT.

Verification
REQ-037 Reset release, ihit=1 three cycles, imemload=A,B,C -> imemaddr 0,4,8; if_instr A,B,C; if_npc 4,8,12; fetch_count=3.
REQ-038 PC=0x40, hazard=1 with ihit=1 two cycles -> PC, IF/ID, fetch_count unchanged; hazard drops -> fetch at 0x40 proceeds.
REQ-039 PC=0x40, jump=1, jump_target=0x100, ihit=1 -> next cycle if_valid=0, imemaddr=0x100, fetch_count unchanged.
REQ-040 PC=0x40, branch=1, branch_target=0x80, ihit=0 three cycles then 1 -> imemaddr 0x40 held during DRAIN, then 0x80; returned word never reaches IF/ID.
REQ-041 halt=1 in FETCH -> imemREN=0, if_valid=0 forever; RST pulse mid-DRAIN -> imemaddr=PC_INIT immediately, state FETCH.
REQ-042 PC=32'hFFFFFFFC, ihit=1 -> PC=0, if_npc=0.
